// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the parametrised synchronous FIFO.
// Contents:
//   fifo_mode_e  - read mode selector (standard registered read or FWFT)
//   ptr_width    - address/pointer width for a given depth
//   count_width  - occupancy counter width for a given depth (holds 0..DEPTH)
//   params_ok    - elaboration-time sanity check of the FIFO parameter set
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // A depth of 1 would give $clog2 == 0, so clamp to one address bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The counter must represent DEPTH itself, hence depth+1 states.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int af_level, input int ae_level,
                                   input int fwft);
    return (width >= 1) && is_pow2(depth) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: WIDTH x DEPTH register array, contents not reset.
// Ports:
//   clk      - write clock
//   wr_en    - write strobe (already qualified by the FIFO accept logic)
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - asynchronous read address
//   rd_data  - asynchronous read data, mem[rd_addr]
module fifo_mem_2p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow pulses and an
// optional first-word-fall-through read mode.
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   data_in, wr_en - write data and write request
//   rd_en          - read request (in FWFT mode: acknowledge/pop)
//   data_out       - read data
//   full, empty    - count == DEPTH / count == 0
//   almost_full    - count >= AF_LEVEL
//   almost_empty   - count <= AE_LEVEL
//   count          - current occupancy
//   overflow       - one-cycle pulse after a rejected write
//   underflow      - one-cycle pulse after a rejected read
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int         PW   = ptr_width(DEPTH);
  localparam int         CW   = count_width(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  generate
    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_params
      $error("sync_fifo_param: illegal parameter set");
    end
  endgenerate

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_rd_data;
  logic [WIDTH-1:0] data_q;
  logic             rd_ok;
  logic             wr_ok;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A full FIFO may still take a write when a read frees a slot in the same cycle.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      data_q    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
        data_q <= mem_rd_data;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en & ~wr_ok;
      underflow <= rd_en & ~rd_ok;
    end
  end

  // FWFT shows the head entry directly; while empty it falls back to the
  // register, which keeps data_out at zero straight out of reset.
  assign data_out = ((MODE == FIFO_FWFT) && !empty) ? mem_rd_data : data_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed, table-driven bench for sync_fifo_param.
// A standard-mode and an FWFT-mode instance share the same stimulus and are
// compared against hand-computed expected values.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         wr_en;
  logic         rd_en;

  logic [W-1:0] dout_std, dout_fw;
  logic         full_std, empty_std, af_std, ae_std, ovf_std, udf_std;
  logic         full_fw, empty_fw, af_fw, ae_fw, ovf_fw, udf_fw;
  logic [3:0]   cnt_std, cnt_fw;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         cnt;
    logic       ovf;
    logic       udf;
    logic [7:0] dstd;
    logic       cstd;
    logic [7:0] dfw;
    logic       cfw;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout_std), .full(full_std), .empty(empty_std),
    .almost_full(af_std), .almost_empty(ae_std), .count(cnt_std),
    .overflow(ovf_std), .underflow(udf_std)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fw (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout_fw), .full(full_fw), .empty(empty_fw),
    .almost_full(af_fw), .almost_empty(ae_fw), .count(cnt_fw),
    .overflow(ovf_fw), .underflow(udf_fw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic wr, input logic rd, input logic [7:0] din,
                        input int cnt, input logic ovf, input logic udf,
                        input logic [7:0] dstd, input logic cstd,
                        input logic [7:0] dfw, input logic cfw);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    v.dstd = dstd; v.cstd = cstd; v.dfw = dfw; v.cfw = cfw;
    vecs.push_back(v);
  endtask

  // Drive inputs, clock once, sample 1 time unit after the edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] din);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    #1;
  endtask

  // Count and flags for both instances; flags decoded from the expected count.
  task automatic checkOutput(input string tag, input int cnt, input logic ovf, input logic udf);
    check({tag, " count std"}, 32'(cnt_std), 32'(cnt));
    check({tag, " count fwft"}, 32'(cnt_fw), 32'(cnt));
    check({tag, " full std"}, 32'(full_std), 32'(cnt == D));
    check({tag, " empty std"}, 32'(empty_std), 32'(cnt == 0));
    check({tag, " almost_full std"}, 32'(af_std), 32'(cnt >= AF));
    check({tag, " almost_empty std"}, 32'(ae_std), 32'(cnt <= AE));
    check({tag, " full fwft"}, 32'(full_fw), 32'(cnt == D));
    check({tag, " empty fwft"}, 32'(empty_fw), 32'(cnt == 0));
    check({tag, " overflow std"}, 32'(ovf_std), 32'(ovf));
    check({tag, " underflow std"}, 32'(udf_std), 32'(udf));
    check({tag, " overflow fwft"}, 32'(ovf_fw), 32'(ovf));
    check({tag, " underflow fwft"}, 32'(udf_fw), 32'(udf));
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] p;

    // Fill 01..08, then a rejected 9th write.
    for (int k = 1; k <= 8; k++) addVec(1, 0, 8'(k), k, 0, 0, 8'h00, 1, 8'h01, 1);
    addVec(1, 0, 8'h09, 8, 1, 0, 8'h00, 1, 8'h01, 1);
    addVec(0, 0, 8'h00, 8, 0, 0, 8'h00, 1, 8'h01, 1);
    // Drain, then a rejected 9th read; data_out holds 08.
    for (int k = 1; k <= 8; k++) addVec(0, 1, 8'h00, 8 - k, 0, 0, 8'(k), 1, 8'(k + 1), (k < 8));
    addVec(0, 1, 8'h00, 0, 0, 1, 8'h08, 1, 8'h00, 0);
    addVec(0, 0, 8'h00, 0, 0, 0, 8'h08, 1, 8'h00, 0);
    // Refill, then simultaneous read/write with AA while full.
    for (int k = 1; k <= 8; k++) addVec(1, 0, 8'(k), k, 0, 0, 8'h08, 1, 8'h01, 1);
    for (int k = 1; k <= 8; k++) addVec(1, 1, 8'hAA, 8, 0, 0, 8'(k), 1, (k < 8) ? 8'(k + 1) : 8'hAA, 1);
    for (int k = 1; k <= 8; k++) addVec(0, 1, 8'h00, 8 - k, 0, 0, 8'hAA, 1, 8'hAA, (k < 8));
    // Empty with both requests: write wins, read rejected.
    addVec(1, 1, 8'h55, 1, 0, 1, 8'hAA, 1, 8'h55, 1);
    addVec(0, 0, 8'h00, 1, 0, 0, 8'hAA, 1, 8'h55, 1);
    addVec(0, 1, 8'h00, 0, 0, 0, 8'h55, 1, 8'h00, 0);
    // Interleaved write/read pairs crossing the pointer wrap several times.
    prev = 8'h55;
    for (int i = 0; i < 20; i++) begin
      p = 8'h10 + 8'(i);
      addVec(1, 0, p, 1, 0, 0, prev, 1, p, 1);
      addVec(0, 1, 8'h00, 0, 0, 0, p, 1, 8'h00, 0);
      prev = p;
    end

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 0);
    check("reset data_out std", 32'(dout_std), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 8'h00);
    checkOutput("idle", 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].din);
      checkOutput(tag, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
      if (vecs[i].cstd) check({tag, " data_out std"}, 32'(dout_std), 32'(vecs[i].dstd));
      if (vecs[i].cfw)  check({tag, " data_out fwft"}, 32'(dout_fw), 32'(vecs[i].dfw));
    end

    // Reset asserted mid-fill clears state without waiting for an edge.
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 8'hC0 + 8'(k));
    applyStimulus(0, 0, 8'h00);
    checkOutput("midfill", 5, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 0, 0, 0);
    check("async reset data_out std", 32'(dout_std), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 8'h00);
    checkOutput("post reset read", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
